enc32to5_seq: RTL and testbench
===============================

// Module: enc32to5_seq
// PURPOSE
//  Sequential 32-to-5 line encoder: converts a 32-line request vector back into
//  5-bit addresses. Captures a multi-hot vector on load and emits the index of
//  every set bit, lowest first, one per valid/ready handshake.
//  Sits downstream of line-select logic to report the active lines as addresses.
// PARAMETERS
//  N   32  number of input lines
//  W   5   index width, W = $clog2(N)
// PORTS
//  clk    in   1    clock, rising edge
//  rst    in   1    synchronous reset, active-high
//  D      in   N    request vector, sampled on accepted load
//  load   in   1    capture D; accepted only when busy=0
//  busy   out  1    1 while state=EMIT
//  A      out  W    index of lowest pending bit; 0 when valid=0
//  valid  out  1    A holds a valid index
//  ready  in   1    consumer accepts A when valid&ready
//  done   out  1    one-cycle pulse: vector fully drained, or empty vector loaded
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high (rst).
//  - Reset values: pending=0, state=IDLE, busy=0, valid=0, A=0, done=0.
//  - rst mid-operation: pending cleared, return to IDLE, no done pulse.
//  - State regs: pending[N-1:0], state {IDLE, EMIT}, done_r.
//  - IDLE: load=1 & D!=0 -> pending<=D, state<=EMIT (valid=1 next cycle).
//    load=1 & D==0 -> stay IDLE, done=1 next cycle.
//  - EMIT: valid=1; A=lowest set bit of pending (combinational from regs).
//    valid&ready -> clear bit A. If it was the last set bit -> state<=IDLE,
//    done=1 next cycle; else stay EMIT, next index visible next cycle.
//  - Throughput: one index per cycle with ready held high.
//    Latency: load -> first valid = 1 cycle.
//  - Backpressure: ready=0 holds A, valid and pending stable.
//  - load while busy=1 is ignored; D is not sampled.
//  - Done cycle is IDLE: a load there is accepted (back-to-back vectors).
//  - Bit 31 handled like any other; D=all-ones takes exactly 32 handshakes.
// CONFIGURATION
//  ENC_REMAIN_CNT_EN defined: adds output CNT [W:0] = popcount(pending).
//  Registered; 0 at reset/IDLE; decrements by 1 per handshake.
//  Not defined: CNT port and its logic absent; all other behaviour identical.
// STRUCTURE
//  Package enc_pkg: ENC_N=32, ENC_W=5, typedef enum {IDLE, EMIT} enc_state_t,
//  function lowest_set(vector) -> index.
//  Sub-module prio_enc32to5: combinational lowest-set-bit encoder.
//  Ports in [31:0], idx [4:0], any; the FSM wraps it.
// TESTING
//  1 rst=1 for 2 cycles -> busy=0 valid=0 A=0 done=0 (CNT=0 if enabled).
//  2 load D=32'h0000_0001, ready=1 -> next cycle valid=1 A=0;
//    following cycle done=1, busy=0.
//  3 load D=32'h8000_0011, ready=1 -> A=0,4,31 on 3 consecutive cycles,
//    then done=1; CNT 3,2,1,0.
//  4 load D=32'h0000_0300, ready=0 for 3 cycles -> A=8 valid=1 stable;
//    ready=1 -> A=8 then 9, then done=1.
//  5 load D=0 -> valid stays 0, done=1 next cycle; load D=32'h4 in done cycle
//    -> A=2 next cycle.
//  6 load D=32'hFFFF_FFFF, ready=1; second load while busy ignored;
//    rst after index 5 -> valid=0, pending=0, no done.

Source files
------------

// File: rtl/enc32to5_seq_pkg.sv
// rtl/enc32to5_seq_pkg.sv - shared sizes, FSM state type and bit-scan helpers for the 32-to-5 encoder
package enc_pkg;

  localparam int ENC_N = 32;
  localparam int ENC_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  // Index of the lowest set bit; 0 when the vector is empty
  function automatic logic [ENC_W-1:0] lowest_set(input logic [ENC_N-1:0] v);
    logic [ENC_W-1:0] idx;
    idx = '0;
    for (int i = ENC_N - 1; i >= 0; i--) begin
      if (v[i]) idx = ENC_W'(i);
    end
    return idx;
  endfunction

  // Number of set bits, wide enough to hold ENC_N
  function automatic logic [ENC_W:0] popcount(input logic [ENC_N-1:0] v);
    logic [ENC_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < ENC_N; i++) begin
      cnt = cnt + (ENC_W+1)'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/enc32to5_seq_if.sv
// rtl/enc32to5_seq_if.sv - load/emit handshake bundle; CNT present only with ENC_REMAIN_CNT_EN
interface enc32to5_seq_if;
  import enc_pkg::*;

  logic [ENC_N-1:0] D;
  logic             load;
  logic             busy;
  logic [ENC_W-1:0] A;
  logic             valid;
  logic             ready;
  logic             done;
`ifdef ENC_REMAIN_CNT_EN
  logic [ENC_W:0]   CNT;

  modport master (output D, load, ready, input busy, A, valid, done, CNT);
  modport slave  (input D, load, ready, output busy, A, valid, done, CNT);
`else
  modport master (output D, load, ready, input busy, A, valid, done);
  modport slave  (input D, load, ready, output busy, A, valid, done);
`endif

endinterface

// File: rtl/enc32to5_seq_prio.sv
// rtl/enc32to5_seq_prio.sv - combinational lowest-set-bit encoder, 32 lines to 5-bit index
module prio_enc32to5
  import enc_pkg::*;
(
  input  logic [ENC_N-1:0] in,
  output logic [ENC_W-1:0] idx,
  output logic             any
);

  // Lowest index wins so addresses come out in ascending order
  always_comb begin
    idx = lowest_set(in);
    any = |in;
  end

endmodule

// File: rtl/enc32to5_seq.sv
// rtl/enc32to5_seq.sv - sequential 32-to-5 encoder draining a captured vector lowest bit first (option ENC_REMAIN_CNT_EN)
module enc32to5_seq
  import enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  enc32to5_seq_if.slave      bus
);

  enc_state_t       state_q, state_d;
  logic [ENC_N-1:0] pending_q, pending_d;
  logic             done_q, done_d;
  logic [ENC_W-1:0] low_idx;
  logic             low_any;
  logic [ENC_N-1:0] cleared;
  logic             emit_w;
  logic             hs;
`ifdef ENC_REMAIN_CNT_EN
  logic [ENC_W:0]   cnt_q, cnt_d;
`endif

  prio_enc32to5 u_prio (
    .in  (pending_q),
    .idx (low_idx),
    .any (low_any)
  );

  // EMIT always holds a non-empty vector, so low_any only confirms it
  assign emit_w    = (state_q == EMIT) && low_any;
  assign hs        = emit_w && bus.ready;
  assign cleared   = pending_q & ~(ENC_N'(1) << low_idx);

  assign bus.busy  = (state_q == EMIT);
  assign bus.valid = emit_w;
  assign bus.A     = emit_w ? low_idx : '0;
  assign bus.done  = done_q;
`ifdef ENC_REMAIN_CNT_EN
  assign bus.CNT   = cnt_q;
`endif

  // Next-state: capture on load in IDLE, retire one bit per handshake in EMIT
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
`ifdef ENC_REMAIN_CNT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (bus.D != '0) begin
            pending_d = bus.D;
            state_d   = EMIT;
`ifdef ENC_REMAIN_CNT_EN
            cnt_d     = popcount(bus.D);
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (hs) begin
          pending_d = cleared;
`ifdef ENC_REMAIN_CNT_EN
          cnt_d     = cnt_q - 1'b1;
`endif
          if (cleared == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  // State registers; reset drops any in-flight vector without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

`ifdef ENC_REMAIN_CNT_EN
  // Remaining-index counter, zero whenever the block is idle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_enc32to5_seq.sv
// tb/tb_enc32to5_seq.sv - directed self-checking bench for enc32to5_seq
module tb_enc32to5_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  enc32to5_seq_if bus ();

  enc32to5_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic busy, input logic valid,
                         input logic [4:0] a, input logic done);
    chk({tag, ".busy"},  32'(bus.busy),  32'(busy));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(valid));
    chk({tag, ".A"},     32'(bus.A),     32'(a));
    chk({tag, ".done"},  32'(bus.done),  32'(done));
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef ENC_REMAIN_CNT_EN
    chk({tag, ".CNT"}, 32'(bus.CNT), 32'(exp));
`else
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  initial begin
    int exp3 [3];
    exp3 = '{0, 4, 31};

    // 1: reset
    rst = 1'b1; bus.load = 1'b0; bus.D = '0; bus.ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_out("reset", 1'b0, 1'b0, 5'd0, 1'b0);
    chk_cnt("reset", 0);

    // 2: single bit 0
    bus.D = 32'h0000_0001; bus.load = 1'b1; bus.ready = 1'b1;
    tick();
    bus.load = 1'b0;
    chk_out("t2.emit", 1'b1, 1'b1, 5'd0, 1'b0);
    chk_cnt("t2.emit", 1);
    tick();
    chk_out("t2.done", 1'b0, 1'b0, 5'd0, 1'b1);
    chk_cnt("t2.done", 0);
    tick();
    chk("t2.done_pulse", 32'(bus.done), 32'd0);

    // 3: bits 0, 4, 31 back to back
    bus.D = 32'h8000_0011; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("t3.idx%0d", i), 1'b1, 1'b1, 5'(exp3[i]), 1'b0);
      chk_cnt($sformatf("t3.idx%0d", i), 3 - i);
      tick();
    end
    chk_out("t3.done", 1'b0, 1'b0, 5'd0, 1'b1);
    chk_cnt("t3.done", 0);

    // 4: backpressure, loaded in the done cycle of test 3
    bus.D = 32'h0000_0300; bus.load = 1'b1; bus.ready = 1'b0;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("t4.hold%0d", i), 1'b1, 1'b1, 5'd8, 1'b0);
      chk_cnt($sformatf("t4.hold%0d", i), 2);
      if (i < 2) tick();
    end
    bus.ready = 1'b1;
    tick();
    chk_out("t4.idx9", 1'b1, 1'b1, 5'd9, 1'b0);
    chk_cnt("t4.idx9", 1);
    tick();
    chk_out("t4.done", 1'b0, 1'b0, 5'd0, 1'b1);

    // 5: empty vector, then reload in its done cycle
    bus.D = 32'h0; bus.load = 1'b1;
    tick();
    chk_out("t5.empty", 1'b0, 1'b0, 5'd0, 1'b1);
    bus.D = 32'h4;
    tick();
    bus.load = 1'b0;
    chk_out("t5.reload", 1'b1, 1'b1, 5'd2, 1'b0);
    tick();
    chk_out("t5.done", 1'b0, 1'b0, 5'd0, 1'b1);
    tick();

    // all-ones drains in exactly 32 handshakes, bit 31 last
    bus.D = 32'hFFFF_FFFF; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("ones.A%0d", i), 32'(bus.A), 32'(i));
      chk($sformatf("ones.done%0d", i), 32'(bus.done), 32'd0);
      tick();
    end
    chk_out("ones.done", 1'b0, 1'b0, 5'd0, 1'b1);
    chk_cnt("ones.done", 0);
    tick();

    // 6: load while busy ignored, reset mid-drain
    bus.D = 32'hFFFF_FFFF; bus.load = 1'b1;
    tick();
    bus.D = 32'h0000_F000;
    for (int i = 0; i < 6; i++) begin
      chk_out($sformatf("t6.idx%0d", i), 1'b1, 1'b1, 5'(i), 1'b0);
      chk_cnt($sformatf("t6.idx%0d", i), 32 - i);
      tick();
    end
    chk_out("t6.ignored", 1'b1, 1'b1, 5'd6, 1'b0);
    rst = 1'b1; bus.load = 1'b0;
    tick();
    rst = 1'b0;
    chk_out("t6.rst", 1'b0, 1'b0, 5'd0, 1'b0);
    chk_cnt("t6.rst", 0);
    tick();
    chk_out("t6.nodone", 1'b0, 1'b0, 5'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
